// File: rtl/apple2_bus_master_if.sv
// Apple II slot-bus signal bundle: clocks, address, selects and host request/response port.
// The master modport is the motherboard/initiator side; the slave modport is the card/host side.
interface apple2_bus_master_if;
   logic        PHI1;
   logic        PHI0;
   logic [15:0] A;
   logic        nWE;
   logic        nDEVSEL;
   logic        nIOSEL;
   logic        nIOSTRB;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;

   modport master (
      output PHI1, PHI0, A, nWE, nDEVSEL, nIOSEL, nIOSTRB,
      output req_ready, rsp_valid, rsp_rdata,
      input  req_valid, req_we, req_addr, req_wdata
   );

   modport slave (
      input  PHI1, PHI0, A, nWE, nDEVSEL, nIOSEL, nIOSTRB,
      input  req_ready, rsp_valid, rsp_rdata,
      output req_valid, req_we, req_addr, req_wdata
   );
endinterface

// File: rtl/apple2_bus_master.sv
// Apple II motherboard-side bus initiator: PHI0/PHI1 from C7M, one 6502-style cycle per
// 1 MHz period, single-slot select decode and host-driven read/write transactions.
module apple2_bus_master #(
   parameter int unsigned SLOT       = 7,
   parameter logic [15:0] IDLE_ADDR  = 16'h0400,
   parameter bit          LONG_CYCLE = 1'b1
) (
   input  logic                C7M,
   input  logic                RES,
   apple2_bus_master_if.master bus,
   inout  wire  [7:0]          D
);
   typedef enum logic [2:0] {
      P1 = 3'd0, P2 = 3'd1, P3 = 3'd2, P4 = 3'd3,
      P5 = 3'd4, P6 = 3'd5, P7 = 3'd6, P8 = 3'd7
   } state_t;

   localparam logic [15:0] DEV_LO  = 16'hC080 + 16'(SLOT * 16);
   localparam logic [15:0] DEV_HI  = DEV_LO + 16'h000F;
   localparam logic [15:0] IO_LO   = 16'hC000 + 16'(SLOT * 256);
   localparam logic [15:0] IO_HI   = IO_LO + 16'h00FF;
   localparam logic [15:0] STRB_LO = 16'hC800;
   localparam logic [15:0] STRB_HI = 16'hCFFF;

   state_t      r_state;
   state_t      w_next;
   logic        w_long;
   logic        w_last;
   logic        w_next_last;
   logic        w_accept;
   logic        w_dec_dev;
   logic        w_dec_io;
   logic        w_dec_strb;

   logic [6:0]  r_cnt;
   logic        r_phi1;
   logic        r_phi0;
   logic [15:0] r_a;
   logic        r_nwe;
   logic        r_ndevsel;
   logic        r_niosel;
   logic        r_niostrb;
   logic        r_active;
   logic [7:0]  r_wdata;
   logic        r_d_oe;
   logic        r_ready;
   logic        r_rsp_valid;
   logic [7:0]  r_rsp_rdata;

   // Bus-cycle state register
   always_ff @(posedge C7M or posedge RES) begin
      if (RES) begin
         r_state <= P1;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state; the 65th cycle (count 64) gets an extra PHI0 state when enabled
   always_comb begin
      w_long      = (LONG_CYCLE == 1'b1) && (r_cnt == 7'd64);
      w_last      = (r_state == P8) || ((r_state == P7) && !w_long);
      w_next      = r_state;
      case (r_state)
         P1:      w_next = P2;
         P2:      w_next = P3;
         P3:      w_next = P4;
         P4:      w_next = P5;
         P5:      w_next = P6;
         P6:      w_next = P7;
         P7:      w_next = w_long ? P8 : P1;
         P8:      w_next = P1;
         default: w_next = P1;
      endcase
      w_next_last = (w_next == P8) || ((w_next == P7) && !w_long);
      w_accept    = bus.req_valid && r_ready;
   end

   // Full 16-bit select decode of the address held for this cycle
   always_comb begin
      w_dec_dev  = (r_a >= DEV_LO)  && (r_a <= DEV_HI);
      w_dec_io   = (r_a >= IO_LO)   && (r_a <= IO_HI);
      w_dec_strb = (r_a >= STRB_LO) && (r_a <= STRB_HI);
   end

   // Clock phases, address/direction, selects, data driver and host handshake
   always_ff @(posedge C7M or posedge RES) begin
      if (RES) begin
         r_cnt       <= 7'd0;
         r_phi1      <= 1'b1;
         r_phi0      <= 1'b0;
         r_a         <= IDLE_ADDR;
         r_nwe       <= 1'b1;
         r_ndevsel   <= 1'b1;
         r_niosel    <= 1'b1;
         r_niostrb   <= 1'b1;
         r_active    <= 1'b0;
         r_wdata     <= 8'h00;
         r_d_oe      <= 1'b0;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 8'h00;
      end else begin
         r_phi1      <= (w_next == P1) || (w_next == P2) || (w_next == P3);
         r_phi0      <= !((w_next == P1) || (w_next == P2) || (w_next == P3));
         r_ready     <= w_next_last;
         r_rsp_valid <= 1'b0;
         if (w_last) begin
            r_cnt       <= (r_cnt == 7'd64) ? 7'd0 : r_cnt + 7'd1;
            r_a         <= w_accept ? bus.req_addr : IDLE_ADDR;
            r_nwe       <= w_accept ? ~bus.req_we : 1'b1;
            r_wdata     <= w_accept ? bus.req_wdata : r_wdata;
            r_active    <= w_accept;
            r_ndevsel   <= 1'b1;
            r_niosel    <= 1'b1;
            r_niostrb   <= 1'b1;
            r_d_oe      <= 1'b0;
            r_rsp_valid <= r_active;
            if (r_active) begin
               r_rsp_rdata <= r_nwe ? D : 8'h00;
            end
         end
         if (r_state == P3) begin
            r_ndevsel <= ~w_dec_dev;
            r_niosel  <= ~w_dec_io;
            r_niostrb <= ~w_dec_strb;
         end
         if (r_state == P4) begin
            r_d_oe <= r_active && !r_nwe;
         end
      end
   end

   assign D             = r_d_oe ? r_wdata : 8'hzz;
   assign bus.PHI1      = r_phi1;
   assign bus.PHI0      = r_phi0;
   assign bus.A         = r_a;
   assign bus.nWE       = r_nwe;
   assign bus.nDEVSEL   = r_ndevsel;
   assign bus.nIOSEL    = r_niosel;
   assign bus.nIOSTRB   = r_niostrb;
   assign bus.req_ready = r_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_apple2_bus_master.sv
// Directed bench for apple2_bus_master (SLOT=6, long cycles on): phase pattern, selects,
// write/read data, back-to-back requests, long-cycle latency and reset mid-write.
module tb_apple2_bus_master;
   logic       C7M;
   logic       RES;
   logic       r_tb_oe;
   logic [7:0] r_tb_d;
   wire  [7:0] D;
   int         checks;
   int         failures;
   int         t;

   apple2_bus_master_if bus ();

   apple2_bus_master #(
      .SLOT      (6),
      .IDLE_ADDR (16'h0400),
      .LONG_CYCLE(1'b1)
   ) dut (
      .C7M (C7M),
      .RES (RES),
      .bus (bus),
      .D   (D)
   );

   assign D = r_tb_oe ? r_tb_d : 8'hzz;

   initial C7M = 1'b0;
   always #5 C7M = ~C7M;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
      end
   endtask

   task automatic clk1();
      @(negedge C7M);
      t++;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         clk1();
         n++;
      end
      check_val("ready_seen", {31'd0, bus.req_ready}, 32'd1);
   endtask

   // Single read; exp_low = {strb,io,dev} selects expected low in P4..P7
   task automatic xfer_read(input logic [15:0] addr, input logic [7:0] dat, input logic [2:0] exp_low);
      wait_ready();
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = addr; bus.req_wdata = 8'hFF;
      r_tb_oe = 1'b1; r_tb_d = dat;
      for (int s = 1; s <= 9; s++) begin
         clk1();
         bus.req_valid = 1'b0;
         if (s <= 7) begin
            check_val("rd_a", {16'd0, bus.A}, {16'd0, addr});
            check_val("rd_nwe", {31'd0, bus.nWE}, 32'd1);
            check_val("rd_d", {24'd0, D}, {24'd0, dat});
            check_val("rd_sel", {29'd0, bus.nIOSTRB, bus.nIOSEL, bus.nDEVSEL},
                      (s >= 4) ? {29'd0, ~exp_low} : 32'd7);
         end else begin
            check_val("rd_sel_off", {29'd0, bus.nIOSTRB, bus.nIOSEL, bus.nDEVSEL}, 32'd7);
         end
         check_val("rd_rspv", {31'd0, bus.rsp_valid}, (s == 8) ? 32'd1 : 32'd0);
         if (s == 8) begin
            check_val("rd_rdata", {24'd0, bus.rsp_rdata}, {24'd0, dat});
            r_tb_oe = 1'b0;
         end
      end
   endtask

   initial begin
      int pos;
      logic exp_rdy;
      checks = 0; failures = 0; t = 0;
      r_tb_oe = 1'b0; r_tb_d = 8'h00;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 16'h0000; bus.req_wdata = 8'h00;
      RES = 1'b1;
      repeat (3) @(negedge C7M);
      check_val("rst_phi1", {31'd0, bus.PHI1}, 32'd1);
      check_val("rst_phi0", {31'd0, bus.PHI0}, 32'd0);
      check_val("rst_a", {16'd0, bus.A}, 32'h0400);
      check_val("rst_nwe", {31'd0, bus.nWE}, 32'd1);
      check_val("rst_sel", {29'd0, bus.nIOSTRB, bus.nIOSEL, bus.nDEVSEL}, 32'd7);
      check_val("rst_ready", {31'd0, bus.req_ready}, 32'd0);
      check_val("rst_rspv", {31'd0, bus.rsp_valid}, 32'd0);
      check_val("rst_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
      RES = 1'b0;
      t = 0;

      // Idle pattern: 64 cycles of 7 states, then one of 8 (t=448..455), then 7 again
      forever begin
         if (t < 448)      pos = t % 7;
         else if (t < 456) pos = t - 448;
         else              pos = (t - 456) % 7;
         exp_rdy = (t >= 448 && t < 456) ? (pos == 7) : (pos == 6);
         check_val("idle_phi1", {31'd0, bus.PHI1}, (pos < 3) ? 32'd1 : 32'd0);
         check_val("idle_phi0", {31'd0, bus.PHI0}, (pos < 3) ? 32'd0 : 32'd1);
         check_val("idle_ready", {31'd0, bus.req_ready}, {31'd0, exp_rdy});
         check_val("idle_a", {16'd0, bus.A}, 32'h0400);
         check_val("idle_sel", {29'd0, bus.nIOSTRB, bus.nIOSEL, bus.nDEVSEL}, 32'd7);
         check_val("idle_rspv", {31'd0, bus.rsp_valid}, 32'd0);
         if (t == 460) break;
         clk1();
      end

      xfer_read(16'hC600, 8'hA9, 3'b010);

      // Back-to-back reads CFFF then C812
      wait_ready();
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'hCFFF;
      r_tb_oe = 1'b1; r_tb_d = 8'h3C;
      for (int s = 1; s <= 16; s++) begin
         clk1();
         check_val("b2b_strb", {31'd0, bus.nIOSTRB},
                   ((s >= 4 && s <= 7) || (s >= 11 && s <= 14)) ? 32'd0 : 32'd1);
         check_val("b2b_a", {16'd0, bus.A},
                   (s <= 7) ? 32'hCFFF : ((s <= 14) ? 32'hC812 : 32'h0400));
         check_val("b2b_rspv", {31'd0, bus.rsp_valid}, (s == 8 || s == 15) ? 32'd1 : 32'd0);
         if (s == 8)  check_val("b2b_rdata1", {24'd0, bus.rsp_rdata}, 32'h3C);
         if (s == 15) check_val("b2b_rdata2", {24'd0, bus.rsp_rdata}, 32'hE7);
         bus.req_valid = 1'b0;
         if (s == 7) begin
            check_val("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b1; bus.req_addr = 16'hC812;
         end
         if (s == 8)  r_tb_d = 8'hE7;
         if (s == 15) r_tb_oe = 1'b0;
      end

      // Write C0E3 = 5A
      wait_ready();
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'hC0E3; bus.req_wdata = 8'h5A;
      for (int s = 1; s <= 9; s++) begin
         clk1();
         bus.req_valid = 1'b0;
         if (s <= 7) begin
            check_val("wr_a", {16'd0, bus.A}, 32'hC0E3);
            check_val("wr_nwe", {31'd0, bus.nWE}, 32'd0);
            check_val("wr_dev", {31'd0, bus.nDEVSEL}, (s >= 4) ? 32'd0 : 32'd1);
            check_val("wr_io", {30'd0, bus.nIOSTRB, bus.nIOSEL}, 32'd3);
            if (s >= 5) check_val("wr_d", {24'd0, D}, 32'h5A);
         end else begin
            check_val("wr_dev_off", {31'd0, bus.nDEVSEL}, 32'd1);
            check_val("wr_nwe_off", {31'd0, bus.nWE}, 32'd1);
         end
         check_val("wr_rspv", {31'd0, bus.rsp_valid}, (s == 8) ? 32'd1 : 32'd0);
         if (s == 8) check_val("wr_rdata", {24'd0, bus.rsp_rdata}, 32'h00);
      end

      // Write aborted by reset in P5
      wait_ready();
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 16'hC0E3; bus.req_wdata = 8'hA5;
      for (int s = 1; s <= 5; s++) begin
         clk1();
         bus.req_valid = 1'b0;
      end
      check_val("abrt_d_pre", {24'd0, D}, 32'hA5);
      check_val("abrt_dev_pre", {31'd0, bus.nDEVSEL}, 32'd0);
      RES = 1'b1;
      #1;
      check_val("abrt_dev", {31'd0, bus.nDEVSEL}, 32'd1);
      check_val("abrt_phi1", {31'd0, bus.PHI1}, 32'd1);
      r_tb_oe = 1'b1; r_tb_d = 8'hC3;
      #1;
      check_val("abrt_d_hiz", {24'd0, D}, 32'hC3);
      r_tb_oe = 1'b0;
      for (int i = 0; i < 4; i++) begin
         clk1();
         check_val("abrt_rst_rspv", {31'd0, bus.rsp_valid}, 32'd0);
         check_val("abrt_rst_dev", {31'd0, bus.nDEVSEL}, 32'd1);
      end
      RES = 1'b0;
      t = 0;
      for (int i = 0; i < 10; i++) begin
         clk1();
         check_val("abrt_post_rspv", {31'd0, bus.rsp_valid}, 32'd0);
         check_val("abrt_post_a", {16'd0, bus.A}, 32'h0400);
      end

      xfer_read(16'hC600, 8'h96, 3'b010);

      // Accept in P7 of count 63 (t=903); executing cycle 64 is long
      while (t < 903) clk1();
      check_val("long_ready_p7", {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'hC0E5;
      r_tb_oe = 1'b1; r_tb_d = 8'h77;
      for (int s = 1; s <= 10; s++) begin
         clk1();
         bus.req_valid = 1'b0;
         check_val("long_ready", {31'd0, bus.req_ready}, (s == 8) ? 32'd1 : 32'd0);
         check_val("long_phi1", {31'd0, bus.PHI1}, (s <= 3 || s >= 9) ? 32'd1 : 32'd0);
         check_val("long_dev", {31'd0, bus.nDEVSEL}, (s >= 4 && s <= 8) ? 32'd0 : 32'd1);
         check_val("long_rspv", {31'd0, bus.rsp_valid}, (s == 9) ? 32'd1 : 32'd0);
         if (s == 9) begin
            check_val("long_rdata", {24'd0, bus.rsp_rdata}, 32'h77);
            r_tb_oe = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
